ext_arbiter: RTL and testbench
==============================

# ext_arbiter

Shares one width-selectable sign/zero extension unit between two pipeline requesters. Requester M is the memory stage (load data for LDURB/LDURH/LDURSW). Requester D is the decode stage (immediates: ALU imm12, D-type imm9, CB imm19, B imm26, MOVZ imm16). M has fixed priority. A saturating starvation counter guarantees D forward progress. The extended 64-bit result is returned one cycle after grant through a registered response port tagged with the requester ID.

## Interface
Parameters:
- MAX_WAIT, 3, consecutive denied cycles after which D beats M; legal range 1..15

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_m  input  1  M request, level; presents field/width/sign this cycle
- field_m  input  32  raw right-justified bits from M
- width_m  input  3  M width code (see Operation)
- sign_m  input  1  1 = sign-extend, 0 = zero-extend
- req_d, field_d, width_d, sign_d  input  1/32/3/1  same meaning for D
- flush_d  input  1  D-stage flush; kills D arbitration this cycle
- gnt_m  output  1  combinational grant to M, same cycle as req_m
- gnt_d  output  1  combinational grant to D, same cycle as req_d
- resp_valid  output  1  registered, one-cycle pulse per granted request
- resp_id  output  1  0 = M, 1 = D; valid with resp_valid
- resp_data  output  64  extended result
- resp_err  output  1  reserved width code was used; valid with resp_valid

## Operation
- Width codes: 0=W8, 1=W9, 2=W12, 3=W16, 4=W19, 5=W26, 6=W32, 7=reserved.
- Extension:
  - out[W-1:0] = field[W-1:0].
  - out[63:W] = field[W-1] when sign is 1, else 0.
  - field bits above W are ignored.
  - Reserved code gives data 0 and resp_err 1.
- Arbitration, at most one grant per cycle:
  - req_d is gated by flush_d; call the result `rd`.
  - If req_m and rd are both set and starve == MAX_WAIT, D is granted.
  - Otherwise, if req_m is set, M is granted.
  - Otherwise, if rd is set, D is granted.
- Starvation counter `starve`:
  - Increments, saturating at MAX_WAIT, when rd is set and gnt_d is 0.
  - Clears on gnt_d, when rd is 0, or on flush_d.
- A requester holds req and operands stable until it sees its grant. A back-to-back new request the next cycle is legal.
- A response is captured for the granted requester only; no grant means resp_valid is 0 next cycle.
- resp_data, resp_id and resp_err hold their last value when resp_valid is 0.

## Timing
- Grant latency 0 cycles (combinational from req, flush_d and starve). Response latency 1 cycle after grant.
- Throughput is one extension per cycle, total across both requesters.
- Reset (reset_n low, asynchronous):
  - resp_valid=0, resp_id=0, resp_data=0, resp_err=0, starve=0.
  - Grants are driven 0 while reset_n is low.
- Reset asserted in the cycle after a grant: that response is lost; resp_valid is 0 immediately.
- flush_d in the cycle of a D grant suppresses that grant. It has no effect on a D response already registered from the previous cycle; the D stage discards it itself.
- Simultaneous flush_d and req_m: M is granted normally and starve clears.

## Structure
- Package ext_pkg:
  - typedef enum logic[2:0] width_t (W8..W32, W_RSVD).
  - localparam REQ_M=1'b0 and REQ_D=1'b1.
  - function width_bits(width_t) returning 8/9/12/16/19/26/32.
- Sub-module ext_unit: combinational variable-width extender. Inputs field[31:0], width_t, sign. Outputs data[63:0] and err. Built from a per-width mux of sign bit and mask.
- ext_arbiter holds the grant logic, the starve counter and the response register, with one ext_unit fed by a 2:1 operand mux on the grant.

## Test plan
- Reset: hold reset_n low with reqs active -> gnt_m=gnt_d=0 and all resp outputs 0. Release -> first grant on the next edge's cycle.
- D alone, field_d=0xFF4, W12:
  - sign 1 -> gnt_d same cycle; next cycle resp_valid=1, id=1, data=0xFFFFFFFFFFFFFFF4.
  - sign 0 -> data=0x0000000000000FF4.
- Both request, M field=0x80 W8 sign 1, D field=0x100 W9 sign 1 -> gnt_m only; next cycle id=0, data=0xFFFFFFFFFFFFFF80. D's data on its later grant is 0xFFFFFFFFFFFFFF00.
- Starvation, MAX_WAIT=3, req_m and req_d held high -> grant sequence M,M,M,D,M,M,M,D; starve reads 0 after each D grant.
- flush_d with req_d alone for 2 cycles -> no grant, resp_valid stays 0, starve=0. Then flush_d low -> gnt_d in that cycle.
- width code 7 on M with field=0xFFFFFFFF -> next cycle resp_valid=1, resp_err=1, data=0. reset_n pulsed low mid-response -> resp_valid drops asynchronously.

Source files
------------

// File: rtl/ext_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ext_pkg
//  Description : Shared types and helpers for the extension arbiter slice.
//                Width codes for the variable-width extender, requester IDs
//                and a helper returning the field width in bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package ext_pkg;

    typedef enum logic [2:0] {
        W8     = 3'd0,
        W9     = 3'd1,
        W12    = 3'd2,
        W16    = 3'd3,
        W19    = 3'd4,
        W26    = 3'd5,
        W32    = 3'd6,
        W_RSVD = 3'd7
    } width_t;

    localparam logic REQ_M = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Number of meaningful field bits for a width code; 0 for the reserved code.
    function automatic logic [5:0] width_bits(input width_t w);
        logic [5:0] bits;
        case (w)
            W8:      bits = 6'd8;
            W9:      bits = 6'd9;
            W12:     bits = 6'd12;
            W16:     bits = 6'd16;
            W19:     bits = 6'd19;
            W26:     bits = 6'd26;
            W32:     bits = 6'd32;
            default: bits = 6'd0;
        endcase
        return bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ext_unit
//  Description : Combinational variable-width sign/zero extender.
//                Ports:
//                  field [31:0] raw right-justified bits
//                  width        width code (width_t)
//                  sign         1 = sign-extend, 0 = zero-extend
//                  data  [63:0] extended result (0 for reserved code)
//                  err          reserved width code used
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_unit
    import ext_pkg::*;
(
    input  logic [31:0] field,
    input  width_t      width,
    input  logic        sign,
    output logic [63:0] data,
    output logic        err
);

    logic [5:0]  w_bits;
    logic [4:0]  w_msb;
    logic [63:0] w_mask;
    logic        w_fill;

    always_comb begin
        w_bits = width_bits(width);
        // For 32 bits the low five bits are 0, so 0-1 wraps to 31 as wanted.
        w_msb  = w_bits[4:0] - 5'd1;
        // 2 << msb gives 2^W without needing a 6-bit shift; minus one is the mask.
        w_mask = (64'd2 << w_msb) - 64'd1;
        w_fill = sign & field[w_msb];

        if (width == W_RSVD) begin
            data = 64'd0;
            err  = 1'b1;
        end else begin
            data = ({32'd0, field} & w_mask) | ({64{w_fill}} & ~w_mask);
            err  = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ext_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ext_arbiter
//  Description : Shares one ext_unit between the memory stage (M, fixed
//                priority) and the decode stage (D). A saturating starvation
//                counter lets D win after MAX_WAIT consecutive denials.
//                Ports:
//                  clk, reset_n          clock, async active-low reset
//                  req_*/field_*/width_*/sign_*   requester operands
//                  flush_d               kills D arbitration this cycle
//                  gnt_m, gnt_d          combinational grants
//                  resp_valid/id/data/err registered response, 1 cycle later
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_arbiter
    import ext_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 3
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_m,
    input  logic [31:0] field_m,
    input  logic [2:0]  width_m,
    input  logic        sign_m,
    input  logic        req_d,
    input  logic [31:0] field_d,
    input  logic [2:0]  width_d,
    input  logic        sign_d,
    input  logic        flush_d,
    output logic        gnt_m,
    output logic        gnt_d,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [63:0] resp_data,
    output logic        resp_err
);

    localparam logic [3:0] c_MAX_STARVE = 4'(MAX_WAIT);

    logic [3:0]  r_starve;
    logic        r_resp_valid;
    logic        r_resp_id;
    logic [63:0] r_resp_data;
    logic        r_resp_err;

    logic        w_rd;
    logic        w_d_wins;
    logic        w_gnt_m;
    logic        w_gnt_d;
    logic [31:0] w_sel_field;
    width_t      w_sel_width;
    logic        w_sel_sign;
    logic [63:0] w_ext_data;
    logic        w_ext_err;

    // Grants are forced low while reset is asserted.
    always_comb begin
        w_rd     = req_d & ~flush_d;
        w_d_wins = w_rd & (~req_m | (r_starve == c_MAX_STARVE));
        w_gnt_d  = reset_n & w_d_wins;
        w_gnt_m  = reset_n & req_m & ~w_d_wins;
    end

    assign gnt_m = w_gnt_m;
    assign gnt_d = w_gnt_d;

    // Operand mux steered by the D grant; M is the default path.
    always_comb begin
        if (w_gnt_d) begin
            w_sel_field = field_d;
            w_sel_width = width_t'(width_d);
            w_sel_sign  = sign_d;
        end else begin
            w_sel_field = field_m;
            w_sel_width = width_t'(width_m);
            w_sel_sign  = sign_m;
        end
    end

    ext_unit u_ext_unit (
        .field (w_sel_field),
        .width (w_sel_width),
        .sign  (w_sel_sign),
        .data  (w_ext_data),
        .err   (w_ext_err)
    );

    // Starvation counter: counts consecutive cycles D asked (unflushed) and
    // lost; any gap, flush or D win restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= 4'd0;
        end else if (!w_rd || w_gnt_d) begin
            r_starve <= 4'd0;
        end else if (r_starve != c_MAX_STARVE) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    // Response register: payload only updates on a grant, holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= REQ_M;
            r_resp_data  <= 64'd0;
            r_resp_err   <= 1'b0;
        end else if (w_gnt_m || w_gnt_d) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= w_gnt_d ? REQ_D : REQ_M;
            r_resp_data  <= w_ext_data;
            r_resp_err   <= w_ext_err;
        end else begin
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_ext_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ext_arbiter
//  Description : Self-checking bench for ext_arbiter. Directed scenarios plus
//                randomized traffic checked against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_arbiter;

    localparam int MAX_WAIT = 3;

    logic        clk;
    logic        reset_n;
    logic        req_m, sign_m, req_d, sign_d, flush_d;
    logic [31:0] field_m, field_d;
    logic [2:0]  width_m, width_d;
    logic        gnt_m, gnt_d, resp_valid, resp_id, resp_err;
    logic [63:0] resp_data;

    int n_vec;
    int n_err;

    // Model state
    int          m_starve;
    logic        m_valid, m_id, m_err;
    logic [63:0] m_data;
    logic        eg_m, eg_d;

    ext_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_m      (req_m),
        .field_m    (field_m),
        .width_m    (width_m),
        .sign_m     (sign_m),
        .req_d      (req_d),
        .field_d    (field_d),
        .width_d    (width_d),
        .sign_d     (sign_d),
        .flush_d    (flush_d),
        .gnt_m      (gnt_m),
        .gnt_d      (gnt_d),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Extension computed arithmetically: value mod 2^W, reinterpreted as a
    // signed W-bit number when sign is set (wraps mod 2^64).
    function automatic logic [63:0] ref_ext(input logic [31:0] f, input logic [2:0] w, input logic s);
        longint unsigned p, v;
        int bits;
        case (w)
            3'd0: bits = 8;
            3'd1: bits = 9;
            3'd2: bits = 12;
            3'd3: bits = 16;
            3'd4: bits = 19;
            3'd5: bits = 26;
            3'd6: bits = 32;
            default: return 64'd0;
        endcase
        p = 64'd1 << bits;
        v = {32'd0, f} % p;
        if (s && v >= p / 2) v = v - p;
        return v;
    endfunction

    task automatic model_reset();
        m_starve = 0;
        m_valid  = 1'b0;
        m_id     = 1'b0;
        m_data   = 64'd0;
        m_err    = 1'b0;
    endtask

    // One clock: check grants/response at negedge, advance model, end at posedge+1.
    task automatic step();
        bit rd;
        @(negedge clk);
        rd = req_d && !flush_d;
        eg_m = 1'b0;
        eg_d = 1'b0;
        if (reset_n) begin
            if (rd && (!req_m || m_starve == MAX_WAIT)) eg_d = 1'b1;
            else if (req_m) eg_m = 1'b1;
        end
        chk("gnt_m", 64'(gnt_m), 64'(eg_m));
        chk("gnt_d", 64'(gnt_d), 64'(eg_d));
        chk("resp_valid", 64'(resp_valid), 64'(m_valid));
        chk("resp_id", 64'(resp_id), 64'(m_id));
        chk("resp_data", resp_data, m_data);
        chk("resp_err", 64'(resp_err), 64'(m_err));
        chk("starve", 64'(dut.r_starve), 64'(m_starve));
        if (!reset_n) begin
            model_reset();
        end else begin
            if (eg_m) begin
                m_valid = 1'b1; m_id = 1'b0;
                m_data = ref_ext(field_m, width_m, sign_m);
                m_err = (width_m == 3'd7);
            end else if (eg_d) begin
                m_valid = 1'b1; m_id = 1'b1;
                m_data = ref_ext(field_d, width_d, sign_d);
                m_err = (width_d == 3'd7);
            end else begin
                m_valid = 1'b0;
            end
            if (rd && !eg_d) m_starve = (m_starve + 1 > MAX_WAIT) ? MAX_WAIT : m_starve + 1;
            else m_starve = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic r, input logic [31:0] f, input logic [2:0] w, input logic s);
        req_m = r; field_m = f; width_m = w; sign_m = s;
    endtask

    task automatic set_d(input logic r, input logic [31:0] f, input logic [2:0] w, input logic s);
        req_d = r; field_d = f; width_d = w; sign_d = s;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        flush_d = 1'b0;
        set_m(1'b1, 32'h12, 3'd0, 1'b1);
        set_d(1'b1, 32'h34, 3'd1, 1'b0);
        model_reset();
        #1;

        // Reset held with requests active
        step();
        step();
        @(posedge clk); #1;
        reset_n = 1'b1;
        step();                                   // first grant after release: M

        // D alone, 0xFF4 W12 signed then unsigned
        set_m(1'b0, 32'h0, 3'd0, 1'b0);
        set_d(1'b1, 32'hFF4, 3'd2, 1'b1);
        step();
        chk("d_w12_s1", resp_data, 64'hFFFFFFFFFFFFFFF4);
        set_d(1'b1, 32'hFF4, 3'd2, 1'b0);
        step();
        chk("d_w12_s0", resp_data, 64'h0000000000000FF4);

        // Both request: M wins, D follows
        set_m(1'b1, 32'h80, 3'd0, 1'b1);
        set_d(1'b1, 32'h100, 3'd1, 1'b1);
        step();
        chk("m_w8", resp_data, 64'hFFFFFFFFFFFFFF80);
        set_m(1'b0, 32'h0, 3'd0, 1'b0);
        step();
        chk("d_w9", resp_data, 64'hFFFFFFFFFFFFFF00);

        // Starvation: both held high for 8 cycles -> M,M,M,D,M,M,M,D
        set_m(1'b1, 32'h7F, 3'd0, 1'b1);
        set_d(1'b1, 32'h1FF, 3'd1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("starve_seq", 64'(eg_d), 64'((i % 4) == 3));
        end

        // Flush holds off D
        set_m(1'b0, 32'h0, 3'd0, 1'b0);
        set_d(1'b1, 32'hABCDE, 3'd4, 1'b1);
        flush_d = 1'b1;
        step();
        step();
        flush_d = 1'b0;
        step();
        chk("d_after_flush_id", 64'(resp_id), 64'd1);

        // Reserved width on M, then async reset during the response
        set_d(1'b0, 32'h0, 3'd0, 1'b0);
        set_m(1'b1, 32'hFFFFFFFF, 3'd7, 1'b1);
        step();
        chk("rsvd_valid", 64'(resp_valid), 64'd1);
        chk("rsvd_err", 64'(resp_err), 64'd1);
        chk("rsvd_data", resp_data, 64'd0);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(resp_valid), 64'd0);
        model_reset();
        set_m(1'b0, 32'h0, 3'd0, 1'b0);
        step();
        reset_n = 1'b1;
        step();

        // Randomized traffic obeying the hold-until-granted protocol
        for (int i = 0; i < 400; i++) begin
            if (!req_m || eg_m)
                set_m(($urandom % 3) != 0, $urandom, 3'($urandom % 8), 1'($urandom % 2));
            if (!req_d || eg_d)
                set_d(($urandom % 3) != 0, $urandom, 3'($urandom % 8), 1'($urandom % 2));
            flush_d = (($urandom % 5) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
